// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control sequencer for the RV32 subset core
//
// Steps each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and
// drives the memory handshakes, IR/PC/regfile enables and PC select.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req / imem_ack        instruction fetch handshake
//   ir_we                      instruction register load pulse
//   dec_mem_read/mem_write/reg_write/branch   decoder flags, sampled in DECODE
//   alu_zero                   ALU zero flag, used in EXEC
//   dmem_req / dmem_we / dmem_ack             data memory handshake
//   reg_we, pc_we, pc_sel      register file / PC control
//   mem_fault                  sticky handshake-timeout flag
//   retired                    retired instruction count (wraps)
//   state_dbg                  current state encoding
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_branch,
    input  logic             alu_zero,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             reg_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             mem_fault,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic              f_mem_read;
    logic              f_mem_write;
    logic              f_reg_write;
    logic              f_branch;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;

    logic imem_req_c;
    logic ir_we_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic reg_we_c;
    logic pc_we_c;
    logic pc_sel_c;

    // The current cycle is the last allowed wait cycle: without an ack now,
    // the counter would reach TIMEOUT. An ack in this cycle still wins.
    assign wait_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        reg_we_c   = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (f_branch) begin
                    pc_we_c   = 1'b1;
                    pc_sel_c  = alu_zero;
                    state_nxt = S_FETCH;
                end else if (f_mem_read || f_mem_write) begin
                    state_nxt = S_MEM;
                end else if (f_reg_write) begin
                    state_nxt = S_WB;
                end else begin
                    pc_we_c   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = f_mem_write;
                if (dmem_ack) begin
                    // A write flag overrides a read flag: treated as a store, no WB.
                    if (f_mem_write) begin
                        pc_we_c   = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_hit) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                reg_we_c  = 1'b1;
                pc_we_c   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            f_mem_read  <= 1'b0;
            f_mem_write <= 1'b0;
            f_reg_write <= 1'b0;
            f_branch    <= 1'b0;
            wait_cnt    <= '0;
            mem_fault   <= 1'b0;
            retired     <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                f_mem_read  <= dec_mem_read;
                f_mem_write <= dec_mem_write;
                f_reg_write <= dec_reg_write;
                f_branch    <= dec_branch;
            end
            // Any state change clears the counter, so it starts at zero on
            // every entry to FETCH or MEM.
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_nxt == S_FAULT) begin
                mem_fault <= 1'b1;
            end
            if (pc_we_c) begin
                retired <= retired + 1'b1;
            end
        end
    end

    // Strobes are gated by rst_n so an asserted reset silences them at once,
    // abandoning any access in flight.
    assign imem_req  = imem_req_c & rst_n;
    assign ir_we     = ir_we_c & rst_n;
    assign dmem_req  = dmem_req_c & rst_n;
    assign dmem_we   = dmem_we_c & rst_n;
    assign reg_we    = reg_we_c & rst_n;
    assign pc_we     = pc_we_c & rst_n;
    assign pc_sel    = pc_sel_c & rst_n;
    assign state_dbg = state;

endmodule
